// File: rtl/sha256_host_ctrl.sv
// Host-side sequencer for the SHA-256 core: loads message words into shared memory,
// kicks the core, waits for completion under a watchdog, then streams h0..h7 out.
module sha256_host_ctrl #(
  parameter int unsigned NUM_OF_WORDS   = 20,
  parameter logic [15:0] MSG_ADDR       = 16'h0000,
  parameter logic [15:0] OUT_ADDR       = 16'h0100,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        core_start,
  output logic [15:0] core_message_addr,
  output logic [15:0] core_output_addr,
  input  logic        core_done,
  output logic        mem_sel,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output logic        busy,
  output logic        error
);

  // state     | meaning
  // LOAD      | accept message words, write them to memory
  // START     | pulse core_start, hand memory to the core
  // WAIT_LOW  | wait for the core to drop its idle/done level
  // WAIT_DONE | wait for done to rise again
  // RD_REQ    | register the read address of hash word k
  // RD_WAIT   | memory latency cycle
  // RD_CAP    | capture read data into the output register
  // OUT       | hold the hash word until out_ready
  typedef enum logic [2:0] {
    S_LOAD, S_START, S_WAIT_LOW, S_WAIT_DONE, S_RD_REQ, S_RD_WAIT, S_RD_CAP, S_OUT
  } state_e;

  localparam logic [7:0]  LAST_IDX  = 8'(NUM_OF_WORDS - 1);
  localparam logic [31:0] WDOG_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_e      state_q;
  logic [7:0]  idx_q;
  logic [2:0]  k_q;
  logic [31:0] wdog_q;
  logic        core_start_q;
  logic        mem_sel_q;
  logic        mem_we_q;
  logic [15:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic        out_valid_q;
  logic        out_last_q;
  logic [31:0] out_data_q;
  logic        error_q;

  logic accept;
  logic wdog_expired;

  assign accept       = in_valid && (state_q == S_LOAD);
  assign wdog_expired = (wdog_q == WDOG_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_LOAD;
      idx_q        <= 8'd0;
      k_q          <= 3'd0;
      wdog_q       <= 32'd0;
      core_start_q <= 1'b0;
      mem_sel_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 16'd0;
      mem_wdata_q  <= 32'd0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_data_q   <= 32'd0;
      error_q      <= 1'b0;
    end else begin
      core_start_q <= 1'b0;
      case (state_q)
        S_LOAD: begin
          if (accept) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= MSG_ADDR + {8'h00, idx_q};
            mem_wdata_q <= in_data;
            if (idx_q == LAST_IDX) begin
              idx_q   <= 8'd0;
              state_q <= S_START;
            end else begin
              idx_q <= idx_q + 8'd1;
            end
          end else begin
            mem_we_q <= 1'b0;
          end
        end
        S_START: begin
          core_start_q <= 1'b1;
          mem_sel_q    <= 1'b1;
          mem_we_q     <= 1'b0;
          wdog_q       <= 32'd0;
          state_q      <= S_WAIT_LOW;
        end
        S_WAIT_LOW: begin
          if (wdog_expired) begin
            error_q   <= 1'b1;
            mem_sel_q <= 1'b0;
            wdog_q    <= 32'd0;
            state_q   <= S_LOAD;
          end else begin
            wdog_q <= wdog_q + 32'd1;
            if (!core_done) state_q <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          // done rising on the expiry cycle still counts as a successful job
          if (core_done) begin
            mem_sel_q <= 1'b0;
            k_q       <= 3'd0;
            wdog_q    <= 32'd0;
            state_q   <= S_RD_REQ;
          end else if (wdog_expired) begin
            error_q   <= 1'b1;
            mem_sel_q <= 1'b0;
            wdog_q    <= 32'd0;
            state_q   <= S_LOAD;
          end else begin
            wdog_q <= wdog_q + 32'd1;
          end
        end
        S_RD_REQ: begin
          mem_addr_q <= OUT_ADDR + {13'h0000, k_q};
          mem_we_q   <= 1'b0;
          state_q    <= S_RD_WAIT;
        end
        S_RD_WAIT: state_q <= S_RD_CAP;
        S_RD_CAP: begin
          out_data_q  <= mem_read_data;
          out_valid_q <= 1'b1;
          out_last_q  <= (k_q == 3'd7);
          state_q     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            if (k_q == 3'd7) begin
              state_q <= S_LOAD;
            end else begin
              k_q     <= k_q + 3'd1;
              state_q <= S_RD_REQ;
            end
          end
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

  assign in_ready          = (state_q == S_LOAD);
  assign busy              = (state_q != S_LOAD) || (idx_q != 8'd0);
  assign core_start        = core_start_q;
  assign core_message_addr = MSG_ADDR;
  assign core_output_addr  = OUT_ADDR;
  assign mem_sel           = mem_sel_q;
  assign mem_we            = mem_we_q;
  assign mem_addr          = mem_addr_q;
  assign mem_write_data    = mem_wdata_q;
  assign out_valid         = out_valid_q;
  assign out_last          = out_last_q;
  assign out_data          = out_data_q;
  assign error             = error_q;

endmodule

// File: tb/tb_sha256_host_ctrl.sv
// Scoreboard bench for sha256_host_ctrl with a stub core and a shared-memory model.
module tb_sha256_host_ctrl;
  localparam int NW = 20;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        core_start;
  logic [15:0] core_message_addr;
  logic [15:0] core_output_addr;
  logic        core_done = 1'b1;
  logic        mem_sel;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        busy;
  logic        error;

  sha256_host_ctrl #(.NUM_OF_WORDS(NW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .core_start(core_start), .core_message_addr(core_message_addr),
    .core_output_addr(core_output_addr), .core_done(core_done),
    .mem_sel(mem_sel), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // shared memory: one-cycle registered read, host writes only when it owns the memory
  logic [31:0] mem [0:511];
  logic [31:0] hash_cur [8];
  logic [31:0] H1 [8];
  logic [31:0] H2 [8];
  logic        stub_wr = 1'b0;

  always @(posedge clk) begin
    if (mem_we && !mem_sel) mem[mem_addr[8:0]] <= mem_write_data;
    if (stub_wr) for (int i = 0; i < 8; i++) mem[9'h100 + 9'(i)] <= hash_cur[i];
    mem_read_data <= mem[mem_addr[8:0]];
  end

  // stub core: done drops 2 cycles after start, rises 10 cycles later with the hash in memory
  int stub_cnt   = 0;
  int start_cnt  = 0;
  int start_cyc  = 0;
  bit never_drop = 1'b0;

  always @(negedge clk) begin
    stub_wr = 1'b0;
    if (stub_cnt != 0 && !never_drop) chk("mem_sel_core_owns", 64'(mem_sel), 64'd1);
    if (core_start) begin
      start_cnt++;
      start_cyc = cyc;
      stub_cnt  = never_drop ? 0 : 1;
    end else if (stub_cnt != 0) begin
      stub_cnt++;
      if (stub_cnt == 2) core_done = 1'b0;
      if (stub_cnt == 12) begin
        core_done = 1'b1;
        stub_wr   = 1'b1;
        stub_cnt  = 0;
      end
    end
  end

  typedef struct packed { logic [31:0] c; logic [15:0] a; logic [31:0] d; } wr_t;
  typedef struct packed { logic last; logic [31:0] data; } out_t;
  wr_t  exp_wr [$];
  out_t exp_out [$];

  always @(negedge clk) begin
    wr_t e;
    if (!reset && mem_we) begin
      if (exp_wr.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL wr_extra: write addr %0h data %0h, none required (cycle %0d)", mem_addr, mem_write_data, cyc);
      end else begin
        e = exp_wr.pop_front();
        chk("wr_cycle", 64'(cyc), 64'(e.c));
        chk("wr_sel_addr_data", 64'({mem_sel, mem_addr, mem_write_data}), 64'({1'b0, e.a, e.d}));
      end
    end
  end

  bit   hold_prev = 1'b0;
  out_t prev;
  always @(negedge clk) begin
    out_t e;
    if (reset) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev)
        chk("out_stable", 64'({out_valid, out_last, out_data}), 64'({1'b1, prev.last, prev.data}));
      if (out_valid && out_ready) begin
        if (exp_out.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL out_extra: word %0h, none required (cycle %0d)", out_data, cyc);
        end else begin
          e = exp_out.pop_front();
          chk("out_word_last", 64'({out_last, out_data}), 64'({e.last, e.data}));
        end
        hold_prev = 1'b0;
      end else if (out_valid) begin
        hold_prev = 1'b1;
        prev      = '{last: out_last, data: out_data};
      end else begin
        hold_prev = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_hash(input bit sel);
    for (int i = 0; i < 8; i++) begin
      hash_cur[i] = sel ? H2[i] : H1[i];
      exp_out.push_back('{last: (i == 7), data: hash_cur[i]});
    end
  endtask

  task automatic load_job(input logic [31:0] base, input int gap);
    int g;
    for (int w = 1; w <= NW; w++) begin
      g = 0;
      in_valid = 1'b1;
      in_data  = base + 32'(w);
      while (!in_ready && g < 200) begin step(); g++; end
      chk("in_ready_load", 64'(in_ready), 64'd1);
      exp_wr.push_back('{c: 32'(cyc + 1), a: 16'(w - 1), d: base + 32'(w)});
      step();
      if (gap > 0) begin
        in_valid = 1'b0;
        repeat (gap) step();
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int g;
    g = 0;
    while (!out_valid && g < 300) begin step(); g++; end
    chk("out_valid_arrives", 64'(out_valid), 64'd1);
  endtask

  task automatic drain(input bit bp, input int nwords);
    for (int i = 0; i < nwords; i++) begin
      wait_out();
      if (bp) begin
        out_ready = 1'b0;
        repeat (5) step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
      end else begin
        step();
      end
    end
  endtask

  task automatic run_job(input logic [31:0] base, input int gap, input bit bp,
                         input bit hsel, input bit junk);
    int s0;
    s0 = start_cnt;
    set_hash(hsel);
    out_ready = !bp;
    load_job(base, gap);
    if (junk) begin
      in_valid = 1'b1;
      in_data  = 32'hDEAD_BEEF;
      wait_out();
      in_valid = 1'b0;
    end
    drain(bp, 8);
    chk("back_to_back_in_ready", 64'(in_ready), 64'd1);
    chk("start_pulses", 64'(start_cnt - s0), 64'd1);
    chk("wr_queue_drained", 64'(exp_wr.size()), 64'd0);
    chk("out_queue_drained", 64'(exp_out.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int g;
    int s0;
    H1 = '{32'h88d4266f, 32'hd4e6338d, 32'h13b845fc, 32'hf289579d,
           32'h209c8978, 32'h23b9217d, 32'ha3e16193, 32'h6f031589};
    H2 = '{32'h01234567, 32'h89abcdef, 32'hfedcba98, 32'h76543210,
           32'h0f1e2d3c, 32'h4b5a6978, 32'h8796a5b4, 32'hc3d2e1f0};
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    out_ready = 1'b0;
    repeat (3) step();
    chk("rst_outputs",
        64'({in_ready, busy, out_valid, out_last, core_start, mem_sel, mem_we, error}),
        64'(8'b1000_0000));
    chk("rst_mem_addr_data", 64'({mem_addr, mem_write_data, out_data}), 64'd0);
    chk("core_addrs", 64'({core_message_addr, core_output_addr}), 64'h0000_0100);
    reset = 1'b0;
    step();

    // contiguous input, always-ready output
    run_job(32'h0000_0000, 0, 1'b0, 1'b0, 1'b0);
    // backpressure on every word, junk on in_valid while the core runs
    run_job(32'hA000_0000, 0, 1'b1, 1'b1, 1'b1);
    // gapped input 1,0,0
    run_job(32'hB000_0000, 2, 1'b0, 1'b0, 1'b0);

    // core never drops done: watchdog expires
    never_drop = 1'b1;
    s0 = start_cnt;
    load_job(32'hC000_0000, 0);
    g = 0;
    while (!error && g < 100) begin step(); g++; end
    chk("timeout_error", 64'(error), 64'd1);
    chk("timeout_cycles", 64'(cyc), 64'(start_cyc + TO));
    chk("timeout_state", 64'({mem_sel, in_ready, busy, out_valid}), 64'(4'b0100));
    chk("timeout_start_pulses", 64'(start_cnt - s0), 64'd1);
    never_drop = 1'b0;
    step();

    run_job(32'hD000_0000, 0, 1'b0, 1'b1, 1'b0);
    chk("error_sticky", 64'(error), 64'd1);

    // reset while presenting hash word k=3
    set_hash(1'b0);
    out_ready = 1'b0;
    load_job(32'hE000_0000, 0);
    drain(1'b1, 3);
    wait_out();
    reset = 1'b1;
    step();
    chk("midjob_reset",
        64'({out_valid, core_start, mem_sel, busy, error, in_ready}), 64'(6'b000001));
    reset = 1'b0;
    exp_out.delete();
    step();

    run_job(32'hF000_0000, 0, 1'b0, 1'b0, 1'b0);
    chk("error_after_reset", 64'(error), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/sha256_host_ctrl.md
Name: sha256_host_ctrl

Overview:
Host-side controller on the other end of the SHA-256 core's start/done and shared-memory interface.
- Accepts message words on a valid/ready stream and writes them into the shared word-addressed memory at MSG_ADDR.
- Pulses core_start, waits for the core to finish, then reads the 8 hash words back from OUT_ADDR.
- Streams the hash words out on a valid/ready port.
- Drives mem_sel, which the top level uses to mux memory ownership between this block (0) and the core (1).

Parameters:
NUM_OF_WORDS, 20, message length in 32-bit words per job (1..255)
MSG_ADDR, 16'h0000, word address of first message word
OUT_ADDR, 16'h0100, word address of first hash word
TIMEOUT_CYCLES, 65535, maximum cycles spent waiting on the core before error

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  message word valid
in_ready  out  1  message word accepted when in_valid and in_ready are both high
in_data  in  32  message word
out_valid  out  1  hash word valid
out_ready  in  1  downstream accepts the hash word
out_data  out  32  hash word h0..h7, in order
out_last  out  1  high with h7
core_start  out  1  start pulse to the core
core_message_addr  out  16  constant MSG_ADDR
core_output_addr  out  16  constant OUT_ADDR
core_done  in  1  core idle/done level (high while the core is idle)
mem_sel  out  1  0 = host owns memory, 1 = core owns memory
mem_we  out  1  memory write enable (registered)
mem_addr  out  16  memory word address (registered)
mem_write_data  out  32  memory write data (registered)
mem_read_data  in  32  valid the cycle after the cycle mem_addr is presented
busy  out  1  a job is in progress
error  out  1  sticky timeout flag

Behaviour:
- Reset (sync, active-high; also applies mid-job):
  - state=LOAD, word index idx=0, hash index k=0, watchdog=0.
  - Outputs: core_start=0, mem_sel=0, mem_we=0, mem_addr=0, mem_write_data=0, out_valid=0, out_last=0, out_data=0, error=0.
  - Any partial job is abandoned; the memory contents left behind are don't-care.
- States: LOAD, START, WAIT_LOW, WAIT_DONE, RD_REQ, RD_WAIT, RD_CAP, OUT.
- LOAD:
  - in_ready=1 only in this state.
  - On each accept: next cycle mem_we=1, mem_addr=MSG_ADDR+idx, mem_write_data=in_data; idx++.
  - mem_we drops the cycle after a cycle with no accept.
  - On the NUM_OF_WORDS-th accept: idx resets to 0 and state goes to START.
  - busy = (idx!=0) in LOAD; busy=1 in all other states.
- START:
  - core_start=1 for exactly one cycle; mem_sel=1; mem_we=0.
  - Go to WAIT_LOW.
- WAIT_LOW: wait for core_done==0, then go to WAIT_DONE. This guards against the core's done level being high while idle.
- WAIT_DONE: on core_done==1, set mem_sel=0, k=0, go to RD_REQ.
- Watchdog:
  - Counts every cycle spent in WAIT_LOW or WAIT_DONE.
  - On reaching TIMEOUT_CYCLES: error=1 (sticky until reset), mem_sel=0, go to LOAD, and discard the job.
- Read-back:
  - RD_REQ: registers mem_addr=OUT_ADDR+k, mem_we=0.
  - RD_WAIT: address is presented to memory.
  - RD_CAP: captures mem_read_data into out_data; out_valid=1 and out_last=(k==7) next cycle.
  - OUT: holds out_data, out_valid and out_last stable until out_ready.
    - On accept with k<7: k++, out_valid=0, go to RD_REQ.
    - On accept with k==7: go to LOAD.
  - Minimum 4 cycles per hash word.
  - out_ready high before out_valid has no effect.
- Width and address rules:
  - Addresses are 16-bit and wrap modulo 2^16; no overflow detection.
  - idx is 8-bit, k is 3-bit.
- Simultaneous events:
  - A core_done rise in the same cycle as a watchdog expiry is treated as success; error is not set.
  - in_valid outside LOAD is ignored.
- Back-to-back jobs: LOAD is re-entered with in_ready=1 on the cycle after the last out accept.

Test Plan:
1. Stub core (drops done 2 cycles after start, raises it 10 cycles later). Stream words 1..20 with in_valid held high → mem writes at addresses 0x0000..0x0013 with data 1..20 on consecutive cycles; exactly one core_start pulse; mem_sel=1 from the start pulse until done rises.
2. Real core with NUM_OF_WORDS=1, in_data=32'h61626364 → out words 88d4266f d4e6338d 13b845fc f289579d 209c8978 23b9217d a3e16193 6f031589; out_last only on the 8th word.
3. Backpressure: out_ready low for 5 cycles on each word → out_data and out_valid stable throughout; 8 words delivered in order with no duplicates.
4. Gapped input (in_valid toggling 1,0,0,1…) → mem_we asserted only in the cycle after each accept; exactly 20 writes.
5. Stub core that never drops done, TIMEOUT_CYCLES=16 → error=1 after 16 wait cycles; mem_sel=0; in_ready=1; error persists through the next job.
6. Reset asserted in OUT with k=3 → next cycle out_valid=0, core_start=0, mem_sel=0, busy=0, error=0; a subsequent full job completes normally.
